// File: rtl/readout_scanner_pkg.sv
// Shared types and constants for the readout scanner and its frame serializer.
package readout_scanner_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StLoad,
    StSend,
    StNext,
    StDone
  } state_e;

  localparam int unsigned FRAME_BYTES  = 4;
  localparam logic [2:0]  HDR_PAD      = 3'b000;
  localparam int unsigned IdxWidth     = 5;
  localparam int unsigned ByteCntWidth = 2;

  // Frame layout, most significant byte first on the wire: {pad, index}, data[23:16..7:0].
  function automatic logic [8*FRAME_BYTES-1:0] build_frame(input logic [IdxWidth-1:0] idx,
                                                           input logic [23:0] data);
    return {HDR_PAD, idx, data};
  endfunction

endpackage

// File: rtl/readout_scanner_frame_serializer.sv
// Presents a 4-byte frame one byte at a time over a valid/ready handshake.
module frame_serializer
  import readout_scanner_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic [8*FRAME_BYTES-1:0] frame_i,
  input  logic                     tx_ready_i,
  output logic [7:0]               tx_data_o,
  output logic                     tx_valid_o,
  output logic                     last_hs_o
);

  localparam logic [ByteCntWidth-1:0] LastByte = ByteCntWidth'(FRAME_BYTES - 1);

  logic [ByteCntWidth-1:0] cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    hs;

  assign hs        = valid_q & tx_ready_i;
  assign last_hs_o = hs & (cnt_q == LastByte);

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (hs) begin
      if (cnt_q == LastByte) begin
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Frame source registers are held for the whole send, so the selected byte is stable in a stall.
  always_comb begin
    tx_data_o = '0;
    if (valid_q) begin
      unique case (cnt_q)
        2'd0: tx_data_o = frame_i[31:24];
        2'd1: tx_data_o = frame_i[23:16];
        2'd2: tx_data_o = frame_i[15:8];
        2'd3: tx_data_o = frame_i[7:0];
      endcase
    end
  end

  assign tx_valid_o = valid_q;

endmodule

// File: rtl/readout_scanner.sv
// Scans NumEntries memory words and streams each as a 4-byte {index, data} frame.
module readout_scanner
  import readout_scanner_pkg::*;
#(
  parameter int unsigned NumEntries = 1,
  parameter int unsigned AddrWidth  = 5,
  parameter int unsigned DataWidth  = 24,
  parameter int unsigned RdLatency  = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  output logic [AddrWidth-1:0] Addr_o,
  input  logic [DataWidth-1:0] Data_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [IdxWidth-1:0] IdxMax  = IdxWidth'(NumEntries - 1);
  localparam logic [1:0]          WaitMax = 2'(RdLatency - 1);

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   index_q, index_d, index_inc;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [23:0]           shadow_q, shadow_d;
  logic [1:0]            wait_q, wait_d;
  logic                  load_frame;
  logic                  last_hs;

  assign index_inc = index_q + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      index_q  <= '0;
      addr_q   <= '0;
      shadow_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      addr_q   <= addr_d;
      shadow_q <= shadow_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i) state_d = StAddr;
      StAddr: state_d = (RdLatency == 0) ? StLoad : StWait;
      StWait: if (wait_q == WaitMax) state_d = StLoad;
      StLoad: state_d = StSend;
      StSend: if (last_hs) state_d = StNext;
      StNext: state_d = (index_q == IdxMax) ? StDone : StAddr;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Address is loaded on entry to ADDR and held until the next ADDR or the return to IDLE.
  always_comb begin
    index_d  = index_q;
    addr_d   = addr_q;
    shadow_d = shadow_q;
    wait_d   = wait_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          index_d = '0;
          addr_d  = '0;
        end
      end
      StAddr: wait_d = '0;
      StWait: wait_d = wait_q + 1'b1;
      StLoad: shadow_d = Data_i[23:0];
      StNext: begin
        if (index_q != IdxMax) begin
          index_d = index_inc;
          addr_d  = AddrWidth'(index_inc);
        end
      end
      StDone: addr_d = '0;
      default: ;
    endcase
  end

  always_comb begin
    busy_o     = (state_q != StIdle) && (state_q != StDone);
    done_o     = (state_q == StDone);
    load_frame = (state_q == StLoad);
  end

  assign Addr_o = addr_q;

  frame_serializer u_ser (
    .clk_i      (clk),
    .rst_ni     (rstn),
    .load_i     (load_frame),
    .frame_i    (build_frame(index_q, shadow_q)),
    .tx_ready_i (tx_ready_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .last_hs_o  (last_hs)
  );

endmodule

// File: tb/tb_readout_scanner.sv
// Directed bench: four scanner instances covering entry counts and read latencies 0..2.
module tb_readout_scanner;

  logic       clk = 1'b0;
  logic       rstn;
  logic       st  [4];
  logic       rdy [4];
  logic [4:0] ad  [4];
  logic [23:0] dat [4];
  logic [7:0] txd [4];
  logic       txv [4];
  logic       bs  [4];
  logic       dn  [4];

  logic [23:0] mem1 [32];
  logic [23:0] mem3 [32];
  logic [23:0] mem2 [32];
  logic [23:0] rd2a;

  int checks = 0;
  int errors = 0;

  logic [7:0] got  [4][16];
  logic [4:0] gota [4][8];
  int nb [4];
  int na [4];
  int dcnt [4];

  logic [7:0] e33 [16];
  logic [7:0] e34 [16];
  logic [7:0] e36 [16];

  always #5 clk = ~clk;

  // u0: one entry, latency 1; u1: three entries, latency 1; u2: two entries, latency 2;
  // u3: three entries, latency 0 with a combinational memory.
  readout_scanner #(.NumEntries(1), .RdLatency(1)) u0 (
    .clk(clk), .rstn(rstn), .start_i(st[0]), .Addr_o(ad[0]), .Data_i(dat[0]),
    .tx_data_o(txd[0]), .tx_valid_o(txv[0]), .tx_ready_i(rdy[0]), .busy_o(bs[0]), .done_o(dn[0])
  );
  readout_scanner #(.NumEntries(3), .RdLatency(1)) u1 (
    .clk(clk), .rstn(rstn), .start_i(st[1]), .Addr_o(ad[1]), .Data_i(dat[1]),
    .tx_data_o(txd[1]), .tx_valid_o(txv[1]), .tx_ready_i(rdy[1]), .busy_o(bs[1]), .done_o(dn[1])
  );
  readout_scanner #(.NumEntries(2), .RdLatency(2)) u2 (
    .clk(clk), .rstn(rstn), .start_i(st[2]), .Addr_o(ad[2]), .Data_i(dat[2]),
    .tx_data_o(txd[2]), .tx_valid_o(txv[2]), .tx_ready_i(rdy[2]), .busy_o(bs[2]), .done_o(dn[2])
  );
  readout_scanner #(.NumEntries(3), .RdLatency(0)) u3 (
    .clk(clk), .rstn(rstn), .start_i(st[3]), .Addr_o(ad[3]), .Data_i(dat[3]),
    .tx_data_o(txd[3]), .tx_valid_o(txv[3]), .tx_ready_i(rdy[3]), .busy_o(bs[3]), .done_o(dn[3])
  );

  always @(posedge clk) begin
    dat[0] <= mem1[ad[0]];
    dat[1] <= mem3[ad[1]];
    rd2a   <= mem2[ad[2]];
    dat[2] <= rd2a;
  end
  assign dat[3] = mem3[ad[3]];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (txv[k] && rdy[k]) begin
        if ((nb[k] % 4) == 0 && na[k] < 8) begin
          gota[k][na[k]] = ad[k];
          na[k]++;
        end
        if (nb[k] < 16) got[k][nb[k]] = txd[k];
        nb[k]++;
      end
      if (dn[k]) dcnt[k]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear(input int k);
    nb[k] = 0;
    na[k] = 0;
    dcnt[k] = 0;
  endtask

  task automatic pulse_start(input int k);
    @(posedge clk);
    #1 st[k] = 1'b1;
    @(posedge clk);
    #1 st[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, input int maxc);
    int n = 0;
    while (!txv[k] && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_valid_timeout", k), {31'd0, txv[k]}, 32'd1);
  endtask

  task automatic wait_done(input int k, input int maxc);
    int n = 0;
    while (!dn[k] && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_done_timeout", k), {31'd0, dn[k]}, 32'd1);
  endtask

  task automatic check_stream(input int k, input int n, input logic [7:0] e [16]);
    chk($sformatf("u%0d_byte_count", k), nb[k], n);
    for (int i = 0; i < n && i < 16; i++) begin
      chk($sformatf("u%0d_byte%0d", k, i), {24'd0, got[k][i]}, {24'd0, e[i]});
    end
  endtask

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      st[k]  = 1'b0;
      rdy[k] = 1'b1;
      clear(k);
    end
    for (int i = 0; i < 32; i++) begin
      mem1[i] = 24'h5A5A5A;
      mem3[i] = 24'hC3C3C3;
      mem2[i] = 24'h969696;
    end
    mem1[0] = 24'hABCDEF;
    mem3[0] = 24'h000001;
    mem3[1] = 24'h000002;
    mem3[2] = 24'hFFFFFF;
    mem2[0] = 24'hABCDEF;
    mem2[1] = 24'h123456;
    e33 = '{8'h00, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    e34 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02,
            8'h02, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    e36 = '{8'h00, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h12, 8'h34, 8'h56,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Reset values
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d_rst_valid", k), {31'd0, txv[k]}, 32'd0);
      chk($sformatf("u%0d_rst_busy", k), {31'd0, bs[k]}, 32'd0);
      chk($sformatf("u%0d_rst_done", k), {31'd0, dn[k]}, 32'd0);
      chk($sformatf("u%0d_rst_addr", k), {27'd0, ad[k]}, 32'd0);
      chk($sformatf("u%0d_rst_data", k), {24'd0, txd[k]}, 32'd0);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d_idle_busy", k), {31'd0, bs[k]}, 32'd0);
      chk($sformatf("u%0d_idle_valid", k), {31'd0, txv[k]}, 32'd0);
    end

    // Single entry, ready high: four back-to-back bytes, then one done pulse
    clear(0);
    pulse_start(0);
    @(negedge clk);
    chk("u0_busy_rise", {31'd0, bs[0]}, 32'd1);
    chk("u0_addr_pre", {31'd0, txv[0]}, 32'd0);
    wait_valid(0, 20);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u0_b2b_data%0d", i), {24'd0, txd[0]}, {24'd0, e33[i]});
      chk($sformatf("u0_b2b_valid%0d", i), {31'd0, txv[0]}, 32'd1);
      @(negedge clk);
    end
    chk("u0_next_valid", {31'd0, txv[0]}, 32'd0);
    chk("u0_next_busy", {31'd0, bs[0]}, 32'd1);
    @(negedge clk);
    chk("u0_done_pulse", {31'd0, dn[0]}, 32'd1);
    chk("u0_done_busy", {31'd0, bs[0]}, 32'd0);
    @(negedge clk);
    chk("u0_done_low", {31'd0, dn[0]}, 32'd0);
    chk("u0_done_count", dcnt[0], 32'd1);
    check_stream(0, 4, e33);

    // Stall on byte1 for five cycles
    clear(0);
    pulse_start(0);
    wait_valid(0, 20);
    chk("u0_stall_b0", {24'd0, txd[0]}, 32'h00);
    @(posedge clk);
    #1 rdy[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("u0_stall_data%0d", i), {24'd0, txd[0]}, 32'hAB);
      chk($sformatf("u0_stall_valid%0d", i), {31'd0, txv[0]}, 32'd1);
    end
    @(posedge clk);
    #1 rdy[0] = 1'b1;
    wait_done(0, 20);
    repeat (3) @(negedge clk);
    check_stream(0, 4, e33);
    chk("u0_stall_done_count", dcnt[0], 32'd1);

    // Three entries, latency 1: 12 bytes and address sequence 0,1,2
    clear(1);
    pulse_start(1);
    wait_done(1, 200);
    repeat (3) @(negedge clk);
    check_stream(1, 12, e34);
    chk("u1_addr_count", na[1], 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u1_addr%0d", i), {27'd0, gota[1][i]}, i);
    end
    chk("u1_done_count", dcnt[1], 32'd1);
    chk("u1_idle_addr", {27'd0, ad[1]}, 32'd0);

    // Three entries, latency 0: identical stream
    clear(3);
    pulse_start(3);
    wait_done(3, 200);
    repeat (3) @(negedge clk);
    check_stream(3, 12, e34);
    chk("u3_done_count", dcnt[3], 32'd1);

    // Two entries, latency 2, second start while busy is ignored
    clear(2);
    pulse_start(2);
    repeat (5) @(posedge clk);
    #1 chk("u2_busy_mid", {31'd0, bs[2]}, 32'd1);
    pulse_start(2);
    repeat (150) @(negedge clk);
    check_stream(2, 8, e36);
    chk("u2_done_count", dcnt[2], 32'd1);
    chk("u2_busy_end", {31'd0, bs[2]}, 32'd0);

    // Asynchronous reset after byte2 of entry 0, then a clean restart
    clear(0);
    pulse_start(0);
    begin
      int n = 0;
      while (!(txv[0] && txd[0] == 8'hCD) && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    chk("u0_reach_b2", {24'd0, txd[0]}, 32'hCD);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("u0_arst_valid", {31'd0, txv[0]}, 32'd0);
    chk("u0_arst_busy", {31'd0, bs[0]}, 32'd0);
    chk("u0_arst_addr", {27'd0, ad[0]}, 32'd0);
    chk("u0_arst_data", {24'd0, txd[0]}, 32'd0);
    chk("u0_arst_bytes", nb[0], 32'd3);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("u0_post_rst_busy", {31'd0, bs[0]}, 32'd0);
    clear(0);
    pulse_start(0);
    wait_done(0, 30);
    repeat (3) @(negedge clk);
    check_stream(0, 4, e33);
    chk("u0_restart_done_count", dcnt[0], 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
